// File: rtl/pipeline_hazard_chain.sv
// In-order stage register chain with stall hold, bubble injection and per-stage flush.
// Youngest-writer operand forwarding with load-use hazard detection; the last stage drives writeback.

module pipeline_hazard_chain_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic              ld_write,
  input  logic [REG_W-1:0]  ld_num,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_ready,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] upd_data,
  output logic              valid,
  output logic              wr_eff,
  output logic [REG_W-1:0]  num,
  output logic [DATA_W-1:0] eff_data,
  output logic              eff_ready
);
  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic              ready_q, ready_d;
  logic [REG_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              upd_act;

  // A result produced for an empty slot has nowhere to go and is dropped.
  always_comb begin
    upd_act   = valid_q & upd_en;
    eff_data  = upd_act ? upd_data : data_q;
    eff_ready = ready_q | upd_act;
    valid     = valid_q;
    wr_eff    = valid_q & write_q;
    num       = num_q;
  end

  always_comb begin
    valid_d = ld_valid;
    write_d = ld_write;
    num_d   = ld_num;
    data_d  = ld_data;
    ready_d = ld_ready;
    if (flush || bubble) begin
      valid_d = 1'b0;
      write_d = 1'b0;
      num_d   = '0;
      data_d  = '0;
      ready_d = 1'b0;
    end else if (hold) begin
      // Held slot still captures results that arrive while it waits.
      valid_d = valid_q;
      write_d = write_q;
      num_d   = num_q;
      data_d  = eff_data;
      ready_d = eff_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      num_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      num_q   <= num_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end
endmodule

module pipeline_hazard_chain #(
  parameter int STAGES     = 4,
  parameter int HOLD_DEPTH = 1,
  parameter int DATA_W     = 16,
  parameter int REG_W      = 3,
  parameter int RD_PORTS   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_write,
  input  logic [REG_W-1:0]             in_writenum,
  input  logic                         stall,
  input  logic [STAGES-1:0]            flush,
  input  logic [STAGES-1:0]            upd_en,
  input  logic [STAGES*DATA_W-1:0]     upd_data,
  input  logic [RD_PORTS*REG_W-1:0]    look_num,
  output logic [RD_PORTS-1:0]          fwd_hit,
  output logic [RD_PORTS*DATA_W-1:0]   fwd_data,
  output logic                         hazard,
  output logic                         wb_write,
  output logic [REG_W-1:0]             wb_num,
  output logic [DATA_W-1:0]            wb_data
);
  logic [STAGES-1:0]                st_valid, st_write, st_ready;
  logic [STAGES-1:0][REG_W-1:0]     st_num;
  logic [STAGES-1:0][DATA_W-1:0]    st_data;
  logic [STAGES-1:0]                st_hold, st_bubble;
  logic [STAGES-1:0]                ld_valid, ld_write, ld_ready;
  logic [STAGES-1:0][REG_W-1:0]     ld_num;
  logic [STAGES-1:0][DATA_W-1:0]    ld_data;
  logic [STAGES-1:0][DATA_W-1:0]    upd_data_a;
  logic [RD_PORTS-1:0][REG_W-1:0]   look_a;
  logic [RD_PORTS-1:0][DATA_W-1:0]  fwd_a;
  logic [RD_PORTS-1:0]              hz_a;

  assign upd_data_a = upd_data;
  assign look_a     = look_num;
  assign fwd_data   = fwd_a;

  // Index 0 is S1. Stall freezes the top HOLD_DEPTH slots and empties the one below them.
  always_comb begin
    ld_valid[0] = in_valid;
    ld_write[0] = in_write;
    ld_num[0]   = in_writenum;
    ld_data[0]  = '0;
    ld_ready[0] = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      ld_valid[i] = st_valid[i-1];
      ld_write[i] = st_write[i-1];
      ld_num[i]   = st_num[i-1];
      ld_data[i]  = st_data[i-1];
      ld_ready[i] = st_ready[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      st_hold[i]   = stall && (i < HOLD_DEPTH);
      st_bubble[i] = stall && (i == HOLD_DEPTH);
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipeline_hazard_chain_stage #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid[g]),
      .ld_write  (ld_write[g]),
      .ld_num    (ld_num[g]),
      .ld_data   (ld_data[g]),
      .ld_ready  (ld_ready[g]),
      .hold      (st_hold[g]),
      .bubble    (st_bubble[g]),
      .flush     (flush[g]),
      .upd_en    (upd_en[g]),
      .upd_data  (upd_data_a[g]),
      .valid     (st_valid[g]),
      .wr_eff    (st_write[g]),
      .num       (st_num[g]),
      .eff_data  (st_data[g]),
      .eff_ready (st_ready[g])
    );
  end

  // Scan oldest to youngest so the youngest matching writer is the last to overwrite.
  always_comb begin
    fwd_hit = '0;
    fwd_a   = '0;
    hz_a    = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int k = STAGES-1; k >= 0; k--) begin
        if (st_write[k] && (st_num[k] == look_a[p])) begin
          fwd_hit[p] = 1'b1;
          fwd_a[p]   = st_ready[k] ? st_data[k] : '0;
          hz_a[p]    = !st_ready[k];
        end
      end
    end
  end

  assign hazard   = |hz_a;
  assign wb_write = st_write[STAGES-1];
  assign wb_num   = st_valid[STAGES-1] ? st_num[STAGES-1]  : '0;
  assign wb_data  = st_valid[STAGES-1] ? st_data[STAGES-1] : '0;
endmodule
